zone_scan_ctrl: RTL and testbench
=================================

Name: zone_scan_ctrl

Overview:
- Timing sequencer for the backlight zone datapath.
- Derives horizontal pixel count, horizontal zone index and vertical row-band index from iDE/iVS, and emits zone, line and frame strobes.
- These outputs drive the 24-way pixel-to-zone demux and the downstream per-zone statistics blocks.
- Built so that every downstream block runs from one timing source instead of each decoding iH_Count ranges itself.

Parameters:
- H_ACTIVE, 1920: active pixels per line.
- ZONE_W, 80: pixels per horizontal zone.
- N_HZONE, 24: horizontal zones. H_ACTIVE = ZONE_W*N_HZONE.
- V_ACTIVE, 1080: active lines per frame.
- ZONE_H, 90: lines per row band.
- N_VZONE, 12: row bands. V_ACTIVE = ZONE_H*N_VZONE.

Ports:
- iODCK  in  1  pixel clock; all logic on its rising edge.
- iRST  in  1  reset. Synchronous, active-high, one clock.
- iDE  in  1  active-video enable.
- iVS  in  1  frame sync; a rising edge restarts vertical counting.
- iY  in  8  pixel luminance.
- oH_Count  out  12  pixel index within the line.
- oZoneIdx  out  5  horizontal zone index, 0..N_HZONE-1.
- oZoneFirst  out  1  first pixel of a zone.
- oZoneLast  out  1  last pixel of a zone.
- oActive  out  1  a valid in-range pixel is on the outputs.
- oY  out  8  iY delayed to align with the other outputs.
- oV_Count  out  11  line index within the frame.
- oRowIdx  out  4  row-band index.
- oLineDone  out  1  one-cycle line-end pulse.
- oFrameDone  out  1  one-cycle frame-end pulse.
- oLineErr  out  1  one-cycle pulse: malformed line.

Behaviour:
- All outputs are registered. Latency is 1 cycle from iDE/iY sampled to the corresponding outputs.
- Reset: all outputs 0. FSM goes to IDLE. Internal de_d and vs_d are cleared to 0. Reset mid-line discards the line with no oLineDone.
- FSM states:
  - IDLE: wait for an iVS rising edge, then go to BLANK. DE is ignored in IDLE.
  - BLANK: an iDE rising edge goes to ACTIVE.
  - ACTIVE: an iDE falling edge goes to BLANK.
- Pixel 0 of a line (DE rise in BLANK):
  - oH_Count=0, oZoneIdx=0, oZoneFirst=1, oActive=1.
  - The zone sub-counter is set to 0.
- Each following cycle with iDE=1:
  - oH_Count increments and the sub-counter increments.
  - When the sub-counter equals ZONE_W-1, oZoneLast=1. On the next pixel the sub-counter wraps to 0, oZoneIdx increments and oZoneFirst=1.
- Overlong line (pixel index >= H_ACTIVE):
  - oActive=0 and oZoneIdx holds at N_HZONE-1.
  - oH_Count saturates at 4095.
  - No further zone strobes.
- DE fall:
  - oLineDone pulses for exactly 1 cycle.
  - oLineErr pulses in the same cycle if the pixel count is not equal to H_ACTIVE.
  - oV_Count increments and the row sub-counter advances. oRowIdx increments every ZONE_H lines.
- Frame end:
  - On the DE fall of line V_ACTIVE-1, oFrameDone pulses together with oLineDone.
  - oV_Count and oRowIdx then wrap to 0.
  - Lines beyond V_ACTIVE: oLineDone still pulses, oLineErr=1, oV_Count holds.
- iVS rising edge:
  - From BLANK: clears oV_Count, oRowIdx and the row sub-counter next cycle.
  - During ACTIVE: the line completes horizontally, oLineErr pulses at its DE fall, and the vertical counters are cleared instead of incremented.
- Single-cycle DE (rise and fall one cycle apart):
  - Pixel 0 is flagged with oZoneFirst=1; oZoneLast=0 unless ZONE_W=1.
  - oLineDone and oLineErr fire on the following cycle.
- oY is iY delayed by one register, so oY is valid whenever oActive=1.

Optional Feature:
- Macro: ZONE_SCAN_ZONE_MAX_EN.
- Extra outputs: oMaxValid (1 bit), oMaxIdx (5 bits), oMaxY (8 bits).
- Accumulation:
  - N_HZONE registers, 8 bits each, hold the running max of iY per horizontal zone over the current row band.
  - Only pixels with oActive=1 update a register.
- Snapshot and readout:
  - On the oLineDone of the last line of a band, the maxima are copied to a shadow bank and the live registers clear to 0.
  - A readout counter then emits oMaxValid=1 for N_HZONE consecutive cycles, with oMaxIdx=0..N_HZONE-1 and oMaxY from the shadow bank.
  - Readout is independent of iDE. A new DE during readout does not stall it.
  - A new snapshot arriving before readout finishes restarts readout at index 0 and sets a sticky internal overrun bit, which is cleared by iRST.
  - iVS rising edge clears the live maxima.
- Without the macro: these ports and all associated logic are absent.

Test Plan:
- iRST high 2 cycles mid-line, then release → all outputs 0, FSM in IDLE. DE pulses before iVS produce no oLineDone.
- iVS pulse, then DE high 1920 cycles → oZoneFirst at oH_Count 0,80,…,1840. oZoneLast at 79,…,1919. oZoneIdx reaches 23. One oLineDone, no oLineErr, oV_Count=1.
- DE high 1925 cycles → oActive=0 for the last 5 pixels, oZoneIdx holds 23, oLineErr=1 with oLineDone.
- 1080 well-formed lines after iVS → oRowIdx steps every 90 lines. oFrameDone coincides with the 1080th oLineDone. oV_Count=0 afterwards.
- iVS rising edge at oH_Count=500 → line completes, oLineErr=1 at its end, next line has oV_Count=0 and oRowIdx=0.
- With ZONE_SCAN_ZONE_MAX_EN: row band where pixel 85 of line 40 has Y=0xC8 and all other pixels have Y=0x10 → after line 89, oMaxValid for 24 cycles. oMaxY=0x10 except oMaxIdx=1, where oMaxY=0xC8.

Source files
------------

// File: rtl/zone_scan_ctrl.sv
// zone_scan_ctrl: single timing source for the backlight zone datapath.
// Turns iDE/iVS into pixel/zone/line/row-band counters and strobes, all
// registered with one cycle of latency from iDE/iY.
// Optional per-zone luminance max readout: define ZONE_SCAN_ZONE_MAX_EN.
module zone_scan_ctrl #(
  parameter int H_ACTIVE = 1920,
  parameter int ZONE_W   = 80,
  parameter int N_HZONE  = 24,
  parameter int V_ACTIVE = 1080,
  parameter int ZONE_H   = 90,
  parameter int N_VZONE  = 12
) (
  input  logic        iODCK,
  input  logic        iRST,
  input  logic        iDE,
  input  logic        iVS,
  input  logic [7:0]  iY,
  output logic [11:0] oH_Count,
  output logic [4:0]  oZoneIdx,
  output logic        oZoneFirst,
  output logic        oZoneLast,
  output logic        oActive,
  output logic [7:0]  oY,
  output logic [10:0] oV_Count,
  output logic [3:0]  oRowIdx,
  output logic        oLineDone,
  output logic        oFrameDone,
  output logic        oLineErr
`ifdef ZONE_SCAN_ZONE_MAX_EN
  ,
  output logic        oMaxValid,
  output logic [4:0]  oMaxIdx,
  output logic [7:0]  oMaxY
`endif
);

  localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] ZW_LAST = 12'(ZONE_W - 1);
  localparam logic [4:0]  HZ_LAST = 5'(N_HZONE - 1);
  localparam logic [10:0] V_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [10:0] ZH_LAST = 11'(ZONE_H - 1);
  localparam logic [3:0]  VZ_LAST = 4'(N_VZONE - 1);
  localparam logic        ZW_ONE  = (ZONE_W == 1);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} stateT;

  stateT       state, stateNext;
  logic        deD, vsD;
  logic        vsPend;     // VS rose mid-line; clear vertical counters at line end
  logic        frameFull;  // V_ACTIVE lines seen since last VS
  logic [11:0] zoneSub;
  logic [10:0] rowSub;

  logic        vsRise, deRise;
  logic        lineStart, pixStep, lineEnd;
  logic [11:0] hInc, subInc;
  logic        inRange, zoneWrap;
  logic [4:0]  zoneNext;
  logic        vsHit, lenErr, lastLine;

  assign vsRise = iVS & ~vsD;
  assign deRise = iDE & ~deD;

  // Next-state decode; also flags what the datapath does this cycle
  always_comb begin
    stateNext = state;
    lineStart = 1'b0;
    pixStep   = 1'b0;
    lineEnd   = 1'b0;
    case (state)
      IDLE:   if (vsRise) stateNext = BLANK;
      BLANK:  if (deRise) begin
                stateNext = ACTIVE;
                lineStart = 1'b1;
              end
      ACTIVE: if (iDE) pixStep = 1'b1;
              else begin
                lineEnd   = 1'b1;
                stateNext = BLANK;
              end
      default: stateNext = IDLE;
    endcase
  end

  // Horizontal next-pixel arithmetic; pixel index saturates at 4095
  assign hInc     = (oH_Count == 12'hFFF) ? oH_Count : oH_Count + 12'd1;
  assign inRange  = (hInc < H_ACT);
  assign zoneWrap = (zoneSub == ZW_LAST);
  assign subInc   = zoneWrap ? 12'd0 : zoneSub + 12'd1;
  assign zoneNext = (zoneWrap && inRange) ? oZoneIdx + 5'd1 : oZoneIdx;

  // Line-end qualifiers: VS seen during the line (now or earlier), bad length
  assign vsHit    = vsPend | vsRise;
  assign lenErr   = (oH_Count != H_LAST);
  assign lastLine = (oV_Count == V_LAST);

  // FSM state and edge-detect history
  always_ff @(posedge iODCK) begin
    if (iRST) begin
      state <= IDLE;
      deD   <= 1'b0;
      vsD   <= 1'b0;
      oY    <= 8'd0;
    end else begin
      state <= stateNext;
      deD   <= iDE;
      vsD   <= iVS;
      oY    <= iY;
    end
  end

  // Horizontal counters and zone strobes
  always_ff @(posedge iODCK) begin
    if (iRST) begin
      oH_Count   <= 12'd0;
      zoneSub    <= 12'd0;
      oZoneIdx   <= 5'd0;
      oZoneFirst <= 1'b0;
      oZoneLast  <= 1'b0;
      oActive    <= 1'b0;
    end else if (lineStart) begin
      oH_Count   <= 12'd0;
      zoneSub    <= 12'd0;
      oZoneIdx   <= 5'd0;
      oZoneFirst <= 1'b1;
      oZoneLast  <= ZW_ONE;
      oActive    <= 1'b1;
    end else if (pixStep) begin
      oH_Count   <= hInc;
      zoneSub    <= subInc;
      oZoneIdx   <= zoneNext;
      oZoneFirst <= inRange & zoneWrap;
      oZoneLast  <= inRange & (subInc == ZW_LAST);
      oActive    <= inRange;
    end else begin
      oZoneFirst <= 1'b0;
      oZoneLast  <= 1'b0;
      oActive    <= 1'b0;
    end
  end

  // Vertical counters, line/frame strobes and VS bookkeeping
  always_ff @(posedge iODCK) begin
    if (iRST) begin
      oV_Count   <= 11'd0;
      rowSub     <= 11'd0;
      oRowIdx    <= 4'd0;
      oLineDone  <= 1'b0;
      oFrameDone <= 1'b0;
      oLineErr   <= 1'b0;
      vsPend     <= 1'b0;
      frameFull  <= 1'b0;
    end else if (lineEnd) begin
      oLineDone <= 1'b1;
      if (vsHit) begin
        // Frame restarted under this line: it is malformed, restart vertically
        oV_Count   <= 11'd0;
        rowSub     <= 11'd0;
        oRowIdx    <= 4'd0;
        vsPend     <= 1'b0;
        frameFull  <= 1'b0;
        oLineErr   <= 1'b1;
        oFrameDone <= 1'b0;
      end else if (frameFull) begin
        // Extra line past V_ACTIVE: flag it and hold the counters
        oLineErr   <= 1'b1;
        oFrameDone <= 1'b0;
      end else begin
        oLineErr <= lenErr;
        if (lastLine) begin
          oFrameDone <= 1'b1;
          oV_Count   <= 11'd0;
          rowSub     <= 11'd0;
          oRowIdx    <= 4'd0;
          frameFull  <= 1'b1;
        end else begin
          oFrameDone <= 1'b0;
          oV_Count   <= oV_Count + 11'd1;
          if (rowSub == ZH_LAST) begin
            rowSub  <= 11'd0;
            oRowIdx <= (oRowIdx == VZ_LAST) ? 4'd0 : oRowIdx + 4'd1;
          end else begin
            rowSub <= rowSub + 11'd1;
          end
        end
      end
    end else begin
      oLineDone  <= 1'b0;
      oFrameDone <= 1'b0;
      oLineErr   <= 1'b0;
      if (vsRise) begin
        if (state == ACTIVE) begin
          vsPend <= 1'b1;
        end else begin
          oV_Count  <= 11'd0;
          rowSub    <= 11'd0;
          oRowIdx   <= 4'd0;
          vsPend    <= 1'b0;
          frameFull <= 1'b0;
        end
      end
    end
  end

`ifdef ZONE_SCAN_ZONE_MAX_EN
  logic [N_HZONE-1:0][7:0] liveMax, shadowMax;
  logic [4:0]              pixZone;
  logic                    pixUpd, bandEnd;
  logic                    overrun;  // sticky: a snapshot cut a readout short

  assign pixZone = lineStart ? 5'd0 : zoneNext;
  assign pixUpd  = lineStart | (pixStep & inRange);
  assign bandEnd = lineEnd & ~vsHit & ~frameFull & (rowSub == ZH_LAST);

  // Running per-zone max over the band, snapshot and sequential readout
  always_ff @(posedge iODCK) begin
    if (iRST) begin
      liveMax   <= '0;
      shadowMax <= '0;
      oMaxValid <= 1'b0;
      oMaxIdx   <= 5'd0;
      oMaxY     <= 8'd0;
      overrun   <= 1'b0;
    end else begin
      if (vsRise || bandEnd)
        liveMax <= '0;
      else if (pixUpd && (iY > liveMax[pixZone]))
        liveMax[pixZone] <= iY;

      if (bandEnd) begin
        shadowMax <= liveMax;
        oMaxValid <= 1'b1;
        oMaxIdx   <= 5'd0;
        oMaxY     <= liveMax[0];
        if (oMaxValid) overrun <= 1'b1;
      end else if (oMaxValid) begin
        if (oMaxIdx == HZ_LAST) begin
          oMaxValid <= 1'b0;
          oMaxIdx   <= 5'd0;
          oMaxY     <= 8'd0;
        end else begin
          oMaxIdx <= oMaxIdx + 5'd1;
          oMaxY   <= shadowMax[oMaxIdx + 5'd1];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_zone_scan_ctrl.sv
// tb_zone_scan_ctrl: directed stimulus with a behavioural scoreboard.
// Runs with shrunken geometry so a full frame fits in a short simulation.
module tb_zone_scan_ctrl;
  localparam int H   = 40;
  localparam int ZW  = 8;
  localparam int NHZ = 5;
  localparam int V   = 12;
  localparam int ZH  = 3;
  localparam int NVZ = 4;

  logic        iODCK = 1'b0;
  logic        iRST = 1'b1, iDE = 1'b0, iVS = 1'b0;
  logic [7:0]  iY = 8'd0;
  logic [11:0] oH_Count;
  logic [4:0]  oZoneIdx;
  logic        oZoneFirst, oZoneLast, oActive;
  logic [7:0]  oY;
  logic [10:0] oV_Count;
  logic [3:0]  oRowIdx;
  logic        oLineDone, oFrameDone, oLineErr;
`ifdef ZONE_SCAN_ZONE_MAX_EN
  logic        oMaxValid;
  logic [4:0]  oMaxIdx;
  logic [7:0]  oMaxY;
`endif

  zone_scan_ctrl #(.H_ACTIVE(H), .ZONE_W(ZW), .N_HZONE(NHZ),
                   .V_ACTIVE(V), .ZONE_H(ZH), .N_VZONE(NVZ)) dut (
    .iODCK(iODCK), .iRST(iRST), .iDE(iDE), .iVS(iVS), .iY(iY),
    .oH_Count(oH_Count), .oZoneIdx(oZoneIdx), .oZoneFirst(oZoneFirst),
    .oZoneLast(oZoneLast), .oActive(oActive), .oY(oY),
    .oV_Count(oV_Count), .oRowIdx(oRowIdx), .oLineDone(oLineDone),
    .oFrameDone(oFrameDone), .oLineErr(oLineErr)
`ifdef ZONE_SCAN_ZONE_MAX_EN
    , .oMaxValid(oMaxValid), .oMaxIdx(oMaxIdx), .oMaxY(oMaxY)
`endif
  );

  always #5 iODCK = ~iODCK;

  typedef struct packed {
    logic        chkH;
    logic [11:0] hc;
    logic [4:0]  zi;
    logic        zf, zl, act;
    logic [7:0]  y;
    logic [10:0] vc;
    logic [3:0]  ri;
    logic        ld, fd, le;
  } expT;

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] y;
  } maxT;

  expT expQ[$];
  maxT maxQ[$];

  int errors = 0, checks = 0;
  int nLd = 0, nFd = 0, nZf = 0, nZl = 0, nLe = 0;

  // Reference state
  int mSt, mPix, mLine;
  bit mDe, mVs, mFull, mPend;
  int live[NHZ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    mSt = 0; mPix = 0; mLine = 0;
    mDe = 0; mVs = 0; mFull = 0; mPend = 0;
    for (int z = 0; z < NHZ; z++) live[z] = 0;
    maxQ.delete();
    expQ.delete();
  endtask

  // Expected outputs one cycle after (de, vs, y) is sampled
  task automatic model(input logic de, input logic vs, input logic [7:0] y, output expT e);
    bit vsR, deR, band, pixOn, inR;
    int idx;
    e = '0;
    e.y = y;
    vsR = vs && !mVs;
    deR = de && !mDe;
    band = 0; pixOn = 0; idx = 0;
    case (mSt)
      0: if (vsR) begin mSt = 1; mLine = 0; mFull = 0; mPend = 0; end
      1: begin
        if (vsR) begin mLine = 0; mFull = 0; mPend = 0; end
        if (deR) begin mSt = 2; idx = 0; pixOn = 1; mPix = 1; end
      end
      default: begin
        if (de) begin
          idx = mPix; pixOn = 1; mPix++;
          if (vsR) mPend = 1;
        end else begin
          e.ld = 1; mSt = 1;
          if (mPend || vsR) begin
            e.le = 1; mLine = 0; mFull = 0; mPend = 0;
          end else if (mFull) begin
            e.le = 1;
          end else begin
            e.le = (mPix != H);
            band = ((mLine % ZH) == ZH - 1);
            if (mLine == V - 1) begin e.fd = 1; mLine = 0; mFull = 1; end
            else mLine++;
          end
        end
      end
    endcase
    inR = 0;
    if (pixOn) begin
      if (idx > 4095) idx = 4095;
      inR = (idx < H);
      e.chkH = 1;
      e.hc = 12'(idx);
      e.act = inR;
      e.zi = inR ? 5'(idx / ZW) : 5'(NHZ - 1);
      e.zf = inR && (idx % ZW == 0);
      e.zl = inR && (idx % ZW == ZW - 1);
    end
    e.vc = 11'(mLine);
    e.ri = 4'(mLine / ZH);
    if (band) begin
      maxQ.delete();
      for (int z = 0; z < NHZ; z++) maxQ.push_back({5'(z), 8'(live[z])});
    end
    if (vsR || band) begin
      for (int z = 0; z < NHZ; z++) live[z] = 0;
    end else if (pixOn && inR && (int'(y) > live[idx / ZW])) begin
      live[idx / ZW] = int'(y);
    end
    mDe = de; mVs = vs;
  endtask

  // One clock: drive, predict, then compare against the popped prediction
  task automatic cyc(input logic de, input logic vs, input logic [7:0] y);
    expT e;
    logic [45:0] obsV, expV;
`ifdef ZONE_SCAN_ZONE_MAX_EN
    maxT m;
    logic [13:0] obsM, expM;
`endif
    iDE = de; iVS = vs; iY = y;
    model(de, vs, y, e);
    expQ.push_back(e);
    @(posedge iODCK); #1;
    e = expQ.pop_front();
    obsV = {e.chkH ? oH_Count : 12'd0, e.chkH ? oZoneIdx : 5'd0, oZoneFirst, oZoneLast,
            oActive, oY, oV_Count, oRowIdx, oLineDone, oFrameDone, oLineErr};
    expV = {e.hc, e.zi, e.zf, e.zl, e.act, e.y, e.vc, e.ri, e.ld, e.fd, e.le};
    chk("cycle", 64'(obsV), 64'(expV));
    nLd += int'(oLineDone); nFd += int'(oFrameDone); nLe += int'(oLineErr);
    nZf += int'(oZoneFirst); nZl += int'(oZoneLast);
`ifdef ZONE_SCAN_ZONE_MAX_EN
    expM = '0;
    if (maxQ.size() > 0) begin
      m = maxQ.pop_front();
      expM = {1'b1, m.idx, m.y};
    end
    obsM = {oMaxValid, oMaxValid ? oMaxIdx : 5'd0, oMaxValid ? oMaxY : 8'd0};
    chk("maxread", 64'(obsM), 64'(expM));
`endif
  endtask

  task automatic rstPulse(input logic de);
    logic [63:0] allOut;
    iRST = 1'b1; iDE = de; iVS = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge iODCK); #1;
      allOut = {oH_Count, oZoneIdx, oZoneFirst, oZoneLast, oActive, oY,
                oV_Count, oRowIdx, oLineDone, oFrameDone, oLineErr};
      chk("reset", allOut, 64'd0);
    end
    iRST = 1'b0;
    modelReset();
  endtask

  // n pixels of DE, optional VS high for 3 pixels from vsAt, hot pixel Y=C8
  task automatic line(input int n, input int vsAt, input int hot);
    for (int p = 0; p < n; p++)
      cyc(1'b1, (vsAt >= 0 && p >= vsAt && p < vsAt + 3), (p == hot) ? 8'hC8 : 8'h10);
    for (int g = 0; g < 3; g++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsPulse();
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int ld0, fd0, le0, zf0, zl0;
    rstPulse(1'b0);

    // Reset in the middle of a line discards it
    vsPulse();
    for (int p = 0; p < 10; p++) cyc(1'b1, 1'b0, 8'(p));
    rstPulse(1'b1);

    // DE activity before any VS is ignored
    ld0 = nLd;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 5; p++) cyc(1'b1, 1'b0, 8'(k + 3));
      for (int p = 0; p < 3; p++) cyc(1'b0, 1'b0, 8'h00);
    end
    chk("noLineBeforeVs", 64'(nLd - ld0), 64'd0);

    // Well-formed line
    vsPulse();
    ld0 = nLd; le0 = nLe; zf0 = nZf; zl0 = nZl;
    line(H, -1, -1);
    chk("goodLineDone", 64'(nLd - ld0), 64'd1);
    chk("goodLineErr", 64'(nLe - le0), 64'd0);
    chk("goodZoneFirst", 64'(nZf - zf0), 64'(NHZ));
    chk("goodZoneLast", 64'(nZl - zl0), 64'(NHZ));
    chk("goodVCount", 64'(oV_Count), 64'd1);

    // Overlong line
    le0 = nLe; zf0 = nZf;
    line(H + 5, -1, -1);
    chk("longLineErr", 64'(nLe - le0), 64'd1);
    chk("longZoneFirst", 64'(nZf - zf0), 64'(NHZ));

    // Single-cycle DE
    le0 = nLe;
    line(1, -1, -1);
    chk("oneLineErr", 64'(nLe - le0), 64'd1);

    // Full frame plus one surplus line
    vsPulse();
    ld0 = nLd; fd0 = nFd; le0 = nLe;
    for (int l = 0; l < V; l++) line(H, -1, (l == 1) ? 9 : -1);
    chk("frameLines", 64'(nLd - ld0), 64'(V));
    chk("frameDone", 64'(nFd - fd0), 64'd1);
    chk("frameNoErr", 64'(nLe - le0), 64'd0);
    chk("frameWrapV", 64'(oV_Count), 64'd0);
    le0 = nLe;
    line(H, -1, -1);
    chk("surplusErr", 64'(nLe - le0), 64'd1);
    chk("surplusHoldV", 64'(oV_Count), 64'd0);

    // VS rising mid-line
    vsPulse();
    line(H, -1, -1);
    line(H, -1, -1);
    le0 = nLe;
    line(H, 20, -1);
    chk("vsMidErr", 64'(nLe - le0), 64'd1);
    chk("vsMidV", 64'(oV_Count), 64'd0);
    chk("vsMidRow", 64'(oRowIdx), 64'd0);
    line(H, -1, -1);
    chk("afterVsV", 64'(oV_Count), 64'd1);
    for (int g = 0; g < 8; g++) cyc(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
